// File: rtl/mips_muldiv_iter_if.sv
// Issue/result bundle between the mips789 core and its iterative HI/LO multiply/divide unit.
// Core drives the issue side (master); the unit returns busy and the HI/LO registers (slave).
interface mips_muldiv_iter_if;
    logic        start_i;
    logic [5:0]  func_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic        stall_i;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, func_i, a_i, b_i, mthi_i, mtlo_i, stall_i,
        input  busy_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, func_i, a_i, b_i, mthi_i, mtlo_i, stall_i,
        output busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/mips_muldiv_iter.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU plus MTHI/MTLO for mips789: 34 cycles start-to-result, start ignored while busy.
// Build with `MULDIV_STALL_EN to let stall_i freeze CALC/FIX; otherwise stall_i is ignored.
module mips_muldiv_iter #(
    parameter logic [5:0] MULT  = 6'd24,
    parameter logic [5:0] MULTU = 6'd25,
    parameter logic [5:0] DIV   = 6'd26,
    parameter logic [5:0] DIVU  = 6'd27,
    parameter int         CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    mips_muldiv_iter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [31:0]        a_raw_q, a_raw_d;
    logic               div_q, div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic        freeze;
`ifdef MULDIV_STALL_EN
    assign freeze = bus.stall_i;
`else
    logic stall_unused;
    assign stall_unused = bus.stall_i;
    assign freeze       = 1'b0;
`endif

    logic        is_op, is_div, is_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign is_div = (bus.func_i == DIV) || (bus.func_i == DIVU);
    assign is_op  = is_div || (bus.func_i == MULT) || (bus.func_i == MULTU);
    assign is_sgn = (bus.func_i == MULT) || (bus.func_i == DIV);
    assign a_neg  = is_sgn && bus.a_i[31];
    assign b_neg  = is_sgn && bus.b_i[31];
    assign a_mag  = a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
    assign b_mag  = b_neg ? (~bus.b_i + 32'd1) : bus.b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Divide: acc = {remainder, dividend/quotient}; remainder < divisor keeps the trial sign bit exact.
    logic [32:0] div_sh, div_trial;
    logic [31:0] div_rem;
    assign div_sh    = {acc_q[63:32], acc_q[31]};
    assign div_trial = div_sh - {1'b0, opnd_q};
    assign div_rem   = div_trial[32] ? div_sh[31:0] : div_trial[31:0];

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = negq_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = negq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        a_raw_d = a_raw_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && is_op) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    div_d   = is_div;
                    a_raw_d = bus.a_i;
                    dz_d    = is_div && (bus.b_i == 32'd0);
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    acc_d   = {32'd0, is_div ? a_mag : b_mag};
                    opnd_d  = is_div ? b_mag : a_mag;
                end else begin
                    if (bus.mthi_i) hi_d = bus.a_i;
                    if (bus.mtlo_i) lo_d = bus.a_i;
                end
            end
            S_CALC: begin
                if (!freeze) begin
                    acc_d = div_q ? {div_rem, acc_q[30:0], ~div_trial[32]}
                                  : {mul_sum, acc_q[31:1]};
                    if (cnt_q == CNT_W'(31)) state_d = S_FIX;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                if (!freeze) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (div_q && dz_q) begin
                        hi_d = a_raw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            a_raw_q <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            a_raw_q <= a_raw_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_iter.sv
// Scoreboard bench for mips_muldiv_iter: driver pushes expected HI/LO and latency, negedge monitor pops and compares.
// Expected values come from plain 64-bit arithmetic on the architectural MULT/DIV definitions.
module tb_mips_muldiv_iter;

    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
`ifdef MULDIV_STALL_EN
    localparam int STALL_LAT = 39;
`else
    localparam int STALL_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ecnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   nops = 0;

    mips_muldiv_iter_if bus_if ();
    mips_muldiv_iter dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct { logic [31:0] hi; logic [31:0] lo; int c0; int lat; } exp_t;
    typedef struct { int tag; logic chk_val; logic [31:0] hi; logic [31:0] lo; logic busy; logic drain; } imm_t;
    exp_t exp_q[$];
    imm_t imm_q[$];

    logic [31:0] m_hi, m_lo;

    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        if (f == F_MULTU)       res = {32'd0, a} * {32'd0, b};
        else if (f == F_MULT)   res = sa * sb;
        else if (b == 32'd0)    res = {a, 32'hFFFF_FFFF};
        else if (f == F_DIVU)   res = {a % b, a / b};
        else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (op %0d): got %h, expected %h", nm, tag, act, exp);
        end
    endtask

    // Monitor: immediate checks first, then busy edges drive the scoreboard.
    logic        prev_busy = 1'b0;
    logic        hold_bad = 1'b0;
    logic [31:0] held_hi, held_lo;
    always @(negedge clk) begin
        imm_t m;
        exp_t e;
        while (imm_q.size() != 0) begin
            m = imm_q.pop_front();
            cmp("imm_busy", m.tag, 32'(bus_if.busy_o), 32'(m.busy));
            if (m.chk_val) begin
                cmp("imm_hi", m.tag, bus_if.hi_o, m.hi);
                cmp("imm_lo", m.tag, bus_if.lo_o, m.lo);
            end
            if (m.drain) cmp("imm_pending", m.tag, exp_q.size(), 0);
        end
        if (!rst) begin
            prev_busy = 1'b0;
        end else begin
            if (!prev_busy && bus_if.busy_o) begin
                held_hi  = bus_if.hi_o;
                held_lo  = bus_if.lo_o;
                hold_bad = 1'b0;
                if (exp_q.size() != 0) cmp("busy_rise_cycle", nops, ecnt - exp_q[0].c0, 1);
            end else if (prev_busy && bus_if.busy_o) begin
                if (bus_if.hi_o !== held_hi || bus_if.lo_o !== held_lo) hold_bad = 1'b1;
            end else if (prev_busy && !bus_if.busy_o) begin
                cmp("op_pending_at_done", nops, 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    cmp("hi", nops, bus_if.hi_o, e.hi);
                    cmp("lo", nops, bus_if.lo_o, e.lo);
                    cmp("done_cycle", nops, ecnt - e.c0, e.lat);
                    cmp("held_while_busy", nops, 32'(hold_bad), 0);
                    nops++;
                end
            end
            prev_busy = bus_if.busy_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_imm(input int tag, input logic chk_val, input logic [31:0] hi,
                            input logic [31:0] lo, input logic busy, input logic drain);
        imm_t m;
        m.tag = tag; m.chk_val = chk_val; m.hi = hi; m.lo = lo; m.busy = busy; m.drain = drain;
        imm_q.push_back(m);
    endtask

    // Returns one cycle after the sampling edge, i.e. in cycle 1 of the operation.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic with_mthi);
        exp_t        e;
        logic [63:0] r;
        r = ref_model(f, a, b);
        bus_if.start_i = 1'b1;
        bus_if.func_i  = f;
        bus_if.a_i     = a;
        bus_if.b_i     = b;
        bus_if.mthi_i  = with_mthi;
        tick();
        e.hi = r[63:32]; e.lo = r[31:0]; e.c0 = ecnt - 1; e.lat = lat;
        exp_q.push_back(e);
        m_hi = r[63:32];
        m_lo = r[31:0];
        bus_if.start_i = 1'b0;
        bus_if.mthi_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus_if.busy_o || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) push_imm(99, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  f;
        bus_if.start_i = 1'b0;
        bus_if.func_i  = '0;
        bus_if.a_i     = '0;
        bus_if.b_i     = '0;
        bus_if.mthi_i  = 1'b0;
        bus_if.mtlo_i  = 1'b0;
        bus_if.stall_i = 1'b0;
        m_hi = '0;
        m_lo = '0;
        rst  = 1'b0;
        repeat (3) tick();
        push_imm(0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0); wait_idle();
        issue(F_MULT,  32'hFFFF_FFFD, 32'd7,         34, 1'b0); wait_idle();
        issue(F_DIV,   32'hFFFF_FFF9, 32'd2,         34, 1'b0); wait_idle();
        issue(F_DIVU,  32'd5,         32'd0,         34, 1'b0); wait_idle();
        issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0); wait_idle();
        issue(F_DIV,   32'hFFFF_FFFB, 32'd0,         34, 1'b0); wait_idle();
        issue(F_DIV,   32'd7,         32'hFFFF_FFFE, 34, 1'b0); wait_idle();
        issue(F_MULT,  32'h8000_0000, 32'h8000_0000, 34, 1'b0); wait_idle();

        // MTHI / MTLO / both in IDLE
        bus_if.mthi_i = 1'b1; bus_if.a_i = 32'h1234_5678; tick(); bus_if.mthi_i = 1'b0;
        m_hi = 32'h1234_5678; push_imm(1, 1'b1, m_hi, m_lo, 1'b0, 1'b0);
        bus_if.mtlo_i = 1'b1; bus_if.a_i = 32'h9ABC_DEF0; tick(); bus_if.mtlo_i = 1'b0;
        m_lo = 32'h9ABC_DEF0; push_imm(2, 1'b1, m_hi, m_lo, 1'b0, 1'b0);
        bus_if.mthi_i = 1'b1; bus_if.mtlo_i = 1'b1; bus_if.a_i = 32'h0F0F_0F0F; tick();
        bus_if.mthi_i = 1'b0; bus_if.mtlo_i = 1'b0;
        m_hi = 32'h0F0F_0F0F; m_lo = 32'h0F0F_0F0F; push_imm(3, 1'b1, m_hi, m_lo, 1'b0, 1'b0);

        // Non-muldiv func on start is ignored
        bus_if.start_i = 1'b1; bus_if.func_i = 6'h20; bus_if.a_i = 32'h55; bus_if.b_i = 32'h3; tick();
        bus_if.start_i = 1'b0;
        push_imm(4, 1'b1, m_hi, m_lo, 1'b0, 1'b0);
        tick();

        // start together with mthi: start wins
        issue(F_MULTU, 32'd3, 32'd4, 34, 1'b1); wait_idle();

        // start at cycle 10 and mthi at cycle 12 of a running op are ignored
        issue(F_MULTU, 32'd3, 32'd4, 34, 1'b0);
        repeat (9) tick();
        bus_if.start_i = 1'b1; bus_if.func_i = F_DIVU; bus_if.a_i = 32'd100; bus_if.b_i = 32'd7;
        tick();
        bus_if.start_i = 1'b0;
        tick();
        bus_if.mthi_i = 1'b1; bus_if.a_i = 32'hDEAD_BEEF; tick(); bus_if.mthi_i = 1'b0;
        wait_idle();
        repeat (3) tick();
        push_imm(5, 1'b1, m_hi, m_lo, 1'b0, 1'b1);

        // stall_i high for cycles 5..9 of CALC
        issue(F_MULTU, 32'd3, 32'd4, STALL_LAT, 1'b0);
        repeat (4) tick();
        bus_if.stall_i = 1'b1; repeat (5) tick(); bus_if.stall_i = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            f = F_MULT + 6'($urandom_range(0, 3));
            issue(f, pick(), pick(), 34, 1'b0);
            wait_idle();
        end

        // Reset asserted at cycle 20 of a DIV clears everything at once
        bus_if.mthi_i = 1'b1; bus_if.mtlo_i = 1'b1; bus_if.a_i = 32'hA5A5_5A5A; tick();
        bus_if.mthi_i = 1'b0; bus_if.mtlo_i = 1'b0;
        m_hi = 32'hA5A5_5A5A; m_lo = 32'hA5A5_5A5A;
        push_imm(6, 1'b1, m_hi, m_lo, 1'b0, 1'b0);
        issue(F_DIV, 32'h1234_5678, 32'd3, 34, 1'b0);
        repeat (19) tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        push_imm(7, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        m_hi = '0; m_lo = '0;
        tick();
        push_imm(8, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();

        issue(F_DIVU, 32'd100, 32'd7, 34, 1'b0); wait_idle();

        repeat (2) tick();
        push_imm(9, 1'b1, m_hi, m_lo, 1'b0, 1'b1);
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
